// File: rtl/yannickreiss_switch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : yannickreiss_switch_sequencer
// Description : Sequences the diamond-crossing switch motor behind red signals
//               and supervises detector feedback, latching a fault on error.
// Revision    : 1.0 - initial release
// ============================================================================
module yannickreiss_switch_sequencer #(
    parameter int CLEAR_DELAY  = 8,
    parameter int MOVE_TIMEOUT = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sig_req,
    input  logic       set_req,
    input  logic       fb_straight,
    input  logic       fb_reverse,
    output logic [3:0] sig_out,
    output logic       motor_en,
    output logic       motor_dir,
    output logic       sw_locked,
    output logic       fault
);

    localparam int c_MAX_CNT = (CLEAR_DELAY > MOVE_TIMEOUT) ? CLEAR_DELAY : MOVE_TIMEOUT;
    localparam int c_CNT_W   = $clog2(c_MAX_CNT + 1);
    localparam logic [c_CNT_W-1:0] c_CLEAR_LAST = c_CNT_W'(CLEAR_DELAY - 1);
    localparam logic [c_CNT_W-1:0] c_MOVE_LAST  = c_CNT_W'(MOVE_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_MOVE  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    state_t              r_state;
    logic                r_pos;
    logic                r_target;
    logic [c_CNT_W-1:0]  r_cnt;

    logic w_fb_ok_pos;
    logic w_fb_ok_target;

    // Both detectors high or both low never counts as a valid confirmation.
    assign w_fb_ok_pos    = (fb_straight == !r_pos)    && (fb_reverse == r_pos);
    assign w_fb_ok_target = (fb_straight == !r_target) && (fb_reverse == r_target);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_pos     <= 1'b0;
            r_target  <= 1'b0;
            r_cnt     <= '0;
            sig_out   <= 4'b0000;
            motor_en  <= 1'b0;
            motor_dir <= 1'b0;
            sw_locked <= 1'b0;
            fault     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (set_req != r_pos) begin
                        r_target  <= set_req;
                        r_cnt     <= '0;
                        sig_out   <= 4'b0000;
                        sw_locked <= 1'b0;
                        r_state   <= ST_CLEAR;
                    end else if (w_fb_ok_pos) begin
                        sig_out   <= sig_req;
                        sw_locked <= 1'b1;
                    end else begin
                        sig_out   <= 4'b0000;
                        sw_locked <= 1'b0;
                        fault     <= 1'b1;
                        r_state   <= ST_FAULT;
                    end
                end
                ST_CLEAR: begin
                    sig_out  <= 4'b0000;
                    motor_en <= 1'b0;
                    if (set_req == r_pos) begin
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                    end else if (r_cnt == c_CLEAR_LAST) begin
                        r_cnt     <= '0;
                        motor_en  <= 1'b1;
                        motor_dir <= r_target;
                        r_state   <= ST_MOVE;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                ST_MOVE: begin
                    // Request changes are deliberately ignored until the move settles.
                    sig_out <= 4'b0000;
                    if (w_fb_ok_target) begin
                        r_pos    <= r_target;
                        r_cnt    <= '0;
                        motor_en <= 1'b0;
                        r_state  <= ST_IDLE;
                    end else if (r_cnt == c_MOVE_LAST) begin
                        motor_en <= 1'b0;
                        fault    <= 1'b1;
                        r_state  <= ST_FAULT;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                ST_FAULT: begin
                    sig_out   <= 4'b0000;
                    motor_en  <= 1'b0;
                    sw_locked <= 1'b0;
                    fault     <= 1'b1;
                end
                default: begin
                    sig_out   <= 4'b0000;
                    motor_en  <= 1'b0;
                    sw_locked <= 1'b0;
                    fault     <= 1'b1;
                    r_state   <= ST_FAULT;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_yannickreiss_switch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_yannickreiss_switch_sequencer
// Description : Vector table, directed corner sequences and randomized plant
//               run against a deadline-based reference of the sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_yannickreiss_switch_sequencer;

    localparam int CLEAR_DELAY  = 4;
    localparam int MOVE_TIMEOUT = 16;

    localparam int PH_LOCK = 0;
    localparam int PH_WAIT = 1;
    localparam int PH_RUN  = 2;
    localparam int PH_DEAD = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] sig_req;
    logic       set_req;
    logic       fb_straight;
    logic       fb_reverse;
    logic [3:0] sig_out;
    logic       motor_en;
    logic       motor_dir;
    logic       sw_locked;
    logic       fault;

    int checks = 0;
    int errors = 0;

    yannickreiss_switch_sequencer #(
        .CLEAR_DELAY (CLEAR_DELAY),
        .MOVE_TIMEOUT(MOVE_TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sig_req    (sig_req),
        .set_req    (set_req),
        .fb_straight(fb_straight),
        .fb_reverse (fb_reverse),
        .sig_out    (sig_out),
        .motor_en   (motor_en),
        .motor_dir  (motor_dir),
        .sw_locked  (sw_locked),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] sig;
        logic       set;
        logic       fs;
        logic       fr;
        logic [3:0] e_sig;
        logic       e_men;
        logic       e_dir;
        logic       e_lock;
        logic       e_fault;
    } vec_t;

    vec_t vq[$];

    // Reference: phase plus absolute-cycle deadlines instead of a counter.
    int         cyc = 0;
    int         m_phase = PH_LOCK;
    int         m_deadline = 0;
    logic       m_pos = 1'b0;
    logic       m_tgt = 1'b0;
    logic [3:0] e_sig = 4'b0000;
    logic       e_men = 1'b0;
    logic       e_dir = 1'b0;
    logic       e_lock = 1'b0;
    logic       e_fault = 1'b0;
    logic       use_model = 1'b0;

    function automatic logic fbok(input logic p);
        return (fb_straight == !p) && (fb_reverse == p);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        cyc++;
        if (rst) begin
            m_phase = PH_LOCK; m_pos = 1'b0; m_tgt = 1'b0;
            e_sig = 4'b0000; e_men = 1'b0; e_dir = 1'b0; e_lock = 1'b0; e_fault = 1'b0;
            return;
        end
        case (m_phase)
            PH_LOCK: begin
                if (set_req != m_pos) begin
                    m_tgt = set_req; m_phase = PH_WAIT; m_deadline = cyc + CLEAR_DELAY;
                    e_sig = 4'b0000; e_lock = 1'b0;
                end else if (fbok(m_pos)) begin
                    e_sig = sig_req; e_lock = 1'b1;
                end else begin
                    m_phase = PH_DEAD; e_sig = 4'b0000; e_lock = 1'b0; e_fault = 1'b1;
                end
            end
            PH_WAIT: begin
                if (set_req == m_pos) m_phase = PH_LOCK;
                else if (cyc == m_deadline) begin
                    m_phase = PH_RUN; e_men = 1'b1; e_dir = m_tgt;
                    m_deadline = cyc + MOVE_TIMEOUT;
                end
            end
            PH_RUN: begin
                if (fbok(m_tgt)) begin
                    m_pos = m_tgt; e_men = 1'b0; m_phase = PH_LOCK;
                end else if (cyc == m_deadline) begin
                    e_men = 1'b0; e_fault = 1'b1; m_phase = PH_DEAD;
                end
            end
            default: ;
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        if (use_model) begin
            chk("model_outputs", {sig_out, motor_en, sw_locked, fault},
                {e_sig, e_men, e_lock, e_fault});
            if (e_men) chk("model_motor_dir", motor_dir, e_dir);
        end
    endtask

    task automatic add_vec(input logic r, input logic [3:0] s, input logic st,
                           input logic fs, input logic fr, input logic [3:0] es,
                           input logic em, input logic ed, input logic el, input logic ef);
        vec_t v;
        v.rst = r; v.sig = s; v.set = st; v.fs = fs; v.fr = fr;
        v.e_sig = es; v.e_men = em; v.e_dir = ed; v.e_lock = el; v.e_fault = ef;
        vq.push_back(v);
    endtask

    task automatic do_reset();
        rst = 1'b1; set_req = 1'b0; fb_straight = 1'b1; fb_reverse = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    logic phys = 1'b0;
    logic prev_men = 1'b0;
    int   travel_left = 0;
    int   dead_cycles = 0;

    initial begin
        int n;
        int men_cycles;
        bit done;

        rst = 1'b1; sig_req = 4'b0101; set_req = 1'b0; fb_straight = 1'b1; fb_reverse = 1'b0;

        // power-up, throw to reverse, withdrawn request, detector fault, reset
        add_vec(1, 4'b0101, 0, 1, 0, 4'b0000, 0, 0, 0, 0);
        add_vec(1, 4'b0101, 0, 1, 0, 4'b0000, 0, 0, 0, 0);
        add_vec(0, 4'b0101, 0, 1, 0, 4'b0101, 0, 0, 1, 0);
        add_vec(0, 4'b1010, 0, 1, 0, 4'b1010, 0, 0, 1, 0);
        add_vec(0, 4'b1010, 1, 1, 0, 4'b0000, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) add_vec(0, 4'b1010, 1, 1, 0, 4'b0000, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) add_vec(0, 4'b1010, 1, 1, 0, 4'b0000, 1, 1, 0, 0);
        add_vec(0, 4'b1010, 1, 0, 1, 4'b0000, 0, 0, 0, 0);
        add_vec(0, 4'b1010, 1, 0, 1, 4'b1010, 0, 0, 1, 0);
        add_vec(0, 4'b1010, 0, 0, 1, 4'b0000, 0, 0, 0, 0);
        add_vec(0, 4'b1010, 0, 0, 1, 4'b0000, 0, 0, 0, 0);
        add_vec(0, 4'b1010, 1, 0, 1, 4'b0000, 0, 0, 0, 0);
        add_vec(0, 4'b1010, 1, 0, 1, 4'b1010, 0, 0, 1, 0);
        add_vec(0, 4'b0111, 1, 0, 1, 4'b0111, 0, 0, 1, 0);
        add_vec(0, 4'b0111, 1, 1, 1, 4'b0000, 0, 0, 0, 1);
        add_vec(0, 4'b0111, 0, 1, 0, 4'b0000, 0, 0, 0, 1);
        add_vec(1, 4'b0111, 0, 1, 0, 4'b0000, 0, 0, 0, 0);
        add_vec(0, 4'b0111, 0, 1, 0, 4'b0111, 0, 0, 1, 0);

        for (int i = 0; i < vq.size(); i++) begin
            rst = vq[i].rst; sig_req = vq[i].sig; set_req = vq[i].set;
            fb_straight = vq[i].fs; fb_reverse = vq[i].fr;
            tick();
            chk($sformatf("vec%0d_sig_out", i), sig_out, vq[i].e_sig);
            chk($sformatf("vec%0d_motor_en", i), motor_en, vq[i].e_men);
            chk($sformatf("vec%0d_sw_locked", i), sw_locked, vq[i].e_lock);
            chk($sformatf("vec%0d_fault", i), fault, vq[i].e_fault);
            if (vq[i].e_men) chk($sformatf("vec%0d_motor_dir", i), motor_dir, vq[i].e_dir);
        end

        // Timeout: feedback never confirms reverse
        sig_req = 4'b1111;
        do_reset();
        tick();
        set_req = 1'b1;
        men_cycles = 0; done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            tick();
            if (motor_en) men_cycles++;
            if (fault) done = 1'b1;
        end
        chk("timeout_fault", fault, 1);
        chk("timeout_motor_cycles", men_cycles, MOVE_TIMEOUT);
        chk("timeout_sig_out", sig_out, 0);
        for (int i = 0; i < 20; i++) begin
            sig_req = 4'($urandom); set_req = 1'($urandom);
            fb_straight = 1'($urandom); fb_reverse = 1'($urandom);
            tick();
            chk("fault_absorbing", {sig_out, motor_en, sw_locked, fault}, 7'b0000001);
        end

        // Request flips back to straight mid-move
        sig_req = 4'b1111;
        do_reset();
        tick();
        chk("mv_locked", sw_locked, 1);
        set_req = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            tick();
            if (motor_en) done = 1'b1;
        end
        chk("mv_motor_started", motor_en, 1);
        set_req = 1'b0;
        tick(); tick(); tick();
        chk("mv_ignores_request", {motor_en, motor_dir}, 2'b11);
        fb_straight = 1'b0; fb_reverse = 1'b1;
        tick();
        chk("mv_confirm_motor_off", motor_en, 0);
        chk("mv_confirm_no_fault", fault, 0);
        tick();
        chk("mv_reclear_sig", sig_out, 0);
        chk("mv_reclear_unlocked", sw_locked, 0);
        n = 0; done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            tick();
            n++;
            if (motor_en) done = 1'b1;
        end
        chk("mv_second_clear_len", n, CLEAR_DELAY);
        chk("mv_second_dir", motor_dir, 0);

        // Randomized run against the reference with a simple switch plant
        rst = 1'b1; phys = 1'b0; travel_left = 0; prev_men = 1'b0;
        fb_straight = 1'b1; fb_reverse = 1'b0; set_req = 1'b0;
        tick(); tick();
        use_model = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            dead_cycles = (m_phase == PH_DEAD) ? dead_cycles + 1 : 0;
            rst = ($urandom_range(0, 199) == 0) || (dead_cycles > 8);
            if (rst) begin
                if ($urandom_range(0, 3) != 0) phys = 1'b0;
                travel_left = 0;
            end
            sig_req = 4'($urandom);
            if ($urandom_range(0, 24) == 0) set_req = ~set_req;
            if (motor_en && travel_left > 0) begin
                fb_straight = 1'b0; fb_reverse = 1'b0;
            end else begin
                fb_straight = !phys; fb_reverse = phys;
            end
            if ($urandom_range(0, 399) == 0) fb_reverse = ~fb_reverse;
            tick();
            if (motor_en && !prev_men) travel_left = $urandom_range(1, 20);
            else if (motor_en && travel_left > 0) travel_left--;
            if (motor_en && travel_left == 0) phys = motor_dir;
            prev_men = motor_en;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
